// File: rtl/cic_seq.sv
`default_nettype none
// ============================================================================
//  Module      : cic_seq
//  Description : CIC decimator sequencer. Gates cic_en, discards settling
//                samples after each start, buffers samples in a show-ahead
//                FIFO with valid/ready output. Optional burst limit when
//                CIC_SEQ_BURST_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module cic_seq #(
   parameter int DATA_WIDTH     = 16,
   parameter int FIFO_DEPTH     = 4,
   parameter int SETTLE_SAMPLES = 5,
   parameter int BURST_WIDTH    = 16
) (
   input  logic                   clk,
   input  logic                   arst_n,
   input  logic                   start,
   input  logic                   stop,
   input  logic [BURST_WIDTH-1:0] burst_len,
   output logic                   cic_en,
   input  logic [DATA_WIDTH-1:0]  cic_data,
   input  logic                   cic_data_clk,
   output logic [DATA_WIDTH-1:0]  m_data,
   output logic                   m_valid,
   input  logic                   m_ready,
   output logic                   busy,
   output logic                   overflow,
   input  logic                   overflow_clr
);

   localparam int             PTR_W     = $clog2(FIFO_DEPTH);
   localparam logic [7:0]     c_settle  = 8'(SETTLE_SAMPLES);
   localparam logic [PTR_W:0] c_ptr_one = {{PTR_W{1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SETTLE = 2'd1,
      S_RUN    = 2'd2
   } state_t;

   state_t                r_state, w_state_nxt;
   logic [7:0]            r_discard, w_discard_nxt;
   logic                  r_strobe;
   logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
   logic [PTR_W:0]        r_wr_ptr, r_rd_ptr;
   logic                  r_overflow;

   logic w_empty, w_full, w_pop, w_push_req, w_push, w_ovf_set;

   // The CIC output settles one cycle after its data_clk, so capture on the delayed strobe
   assign w_empty    = (r_wr_ptr == r_rd_ptr);
   assign w_full     = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                       (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
   assign w_pop      = !w_empty && m_ready;
   assign w_push_req = (r_state == S_RUN) && r_strobe && !stop;
   assign w_push     = w_push_req && (!w_full || w_pop);
   assign w_ovf_set  = w_push_req && w_full && !w_pop;

`ifdef CIC_SEQ_BURST_EN
   logic [BURST_WIDTH-1:0] r_burst, w_burst_nxt;
`else
   logic w_unused_burst;
   assign w_unused_burst = ^burst_len;
`endif

   always_comb begin
      w_state_nxt   = r_state;
      w_discard_nxt = r_discard;
`ifdef CIC_SEQ_BURST_EN
      w_burst_nxt   = r_burst;
`endif
      case (r_state)
         S_IDLE: begin
            if (start && !stop) begin
               w_discard_nxt = c_settle;
`ifdef CIC_SEQ_BURST_EN
               w_burst_nxt   = burst_len;
`endif
               w_state_nxt   = (c_settle == 8'd0) ? S_RUN : S_SETTLE;
            end
         end
         S_SETTLE: begin
            if (stop) begin
               w_state_nxt = S_IDLE;
            end else if (r_strobe) begin
               w_discard_nxt = r_discard - 8'd1;
               if (r_discard == 8'd1) w_state_nxt = S_RUN;
            end
         end
         S_RUN: begin
            if (stop) begin
               w_state_nxt = S_IDLE;
            end
`ifdef CIC_SEQ_BURST_EN
            // A zero count stays zero and means unlimited
            else if (w_push && (r_burst != '0)) begin
               w_burst_nxt = r_burst - 1'b1;
               if (r_burst == {{(BURST_WIDTH-1){1'b0}}, 1'b1}) w_state_nxt = S_IDLE;
            end
`endif
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         r_state   <= S_IDLE;
         r_discard <= 8'd0;
         r_strobe  <= 1'b0;
`ifdef CIC_SEQ_BURST_EN
         r_burst   <= '0;
`endif
      end else begin
         r_state   <= w_state_nxt;
         r_discard <= w_discard_nxt;
         r_strobe  <= cic_data_clk;
`ifdef CIC_SEQ_BURST_EN
         r_burst   <= w_burst_nxt;
`endif
      end
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_push) begin
            r_mem[r_wr_ptr[PTR_W-1:0]] <= cic_data;
            r_wr_ptr <= r_wr_ptr + c_ptr_one;
         end
         if (w_pop) r_rd_ptr <= r_rd_ptr + c_ptr_one;
         if (w_ovf_set)         r_overflow <= 1'b1;
         else if (overflow_clr) r_overflow <= 1'b0;
      end
   end

   assign cic_en   = (r_state != S_IDLE);
   assign busy     = (r_state != S_IDLE);
   assign m_valid  = !w_empty;
   assign m_data   = r_mem[r_rd_ptr[PTR_W-1:0]];
   assign overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_cic_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cic_seq
//  Description : Directed self-checking bench for cic_seq (default params).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cic_seq;

   logic        clk = 1'b0;
   logic        arst_n = 1'b0;
   logic        start = 1'b0;
   logic        stop = 1'b0;
   logic [15:0] burst_len = 16'd0;
   logic        cic_en;
   logic [15:0] cic_data = 16'd0;
   logic        cic_data_clk = 1'b0;
   logic [15:0] m_data;
   logic        m_valid;
   logic        m_ready = 1'b0;
   logic        busy;
   logic        overflow;
   logic        overflow_clr = 1'b0;

   int n_checks = 0;
   int n_fail   = 0;

   cic_seq dut (
      .clk          (clk),
      .arst_n       (arst_n),
      .start        (start),
      .stop         (stop),
      .burst_len    (burst_len),
      .cic_en       (cic_en),
      .cic_data     (cic_data),
      .cic_data_clk (cic_data_clk),
      .m_data       (m_data),
      .m_valid      (m_valid),
      .m_ready      (m_ready),
      .busy         (busy),
      .overflow     (overflow),
      .overflow_clr (overflow_clr)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   // CIC-like strobe: data_out changes on the edge ending data_clk; returns
   // just after the edge at which the delayed strobe captures the sample.
   task automatic send(input logic [15:0] v, input logic rdy);
      @(negedge clk);
      cic_data_clk = 1'b1;
      @(negedge clk);
      cic_data_clk = 1'b0;
      cic_data     = v;
      m_ready      = rdy;
      @(posedge clk); #1;
   endtask

   task automatic gap(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_start();
      @(negedge clk);
      start = 1'b1;
      @(posedge clk); #1;
      check("start_busy", 32'(busy), 1);
      check("start_cic_en", 32'(cic_en), 1);
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic settle(input logic rdy);
      for (int i = 0; i < 5; i++) begin
         send(16'hA000 + 16'(i), rdy);
         check("settle_discard", 32'(m_valid), 0);
         gap(6);
      end
   endtask

   initial begin
      // Reset values
      repeat (2) @(negedge clk);
      check("rst_cic_en", 32'(cic_en), 0);
      check("rst_m_valid", 32'(m_valid), 0);
      check("rst_m_data", 32'(m_data), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_overflow", 32'(overflow), 0);
      arst_n = 1'b1;

      // Five discards, sixth sample appears two cycles after its strobe
      do_start();
      settle(1'b1);
      send(16'h1234, 1'b1);
      check("first_valid", 32'(m_valid), 1);
      check("first_data", 32'(m_data), 32'h1234);
      @(posedge clk); #1;
      check("first_popped", 32'(m_valid), 0);
      gap(4);

      // Overflow with m_ready low
      for (int i = 1; i <= 6; i++) begin
         send(16'(i), 1'b0);
         gap(6);
      end
      check("ovf_set", 32'(overflow), 1);
      check("ovf_head", 32'(m_data), 1);
      @(negedge clk);
      overflow_clr = 1'b1;
      @(posedge clk); #1;
      check("ovf_clr", 32'(overflow), 0);
      @(negedge clk);
      overflow_clr = 1'b0;
      m_ready      = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         check("drain_valid", 32'(m_valid), 1);
         check("drain_data", 32'(m_data), 32'(i));
         @(posedge clk); #1;
      end
      check("drain_empty", 32'(m_valid), 0);

      // Full FIFO with a pop in the capture cycle
      for (int i = 0; i < 4; i++) send(16'h0011 + 16'(i), 1'b0);
      send(16'h0015, 1'b1);
      check("fullpop_ovf", 32'(overflow), 0);
      for (int i = 0; i < 4; i++) begin
         check("fullpop_valid", 32'(m_valid), 1);
         check("fullpop_data", 32'(m_data), 32'h12 + 32'(i));
         @(posedge clk); #1;
      end
      check("fullpop_empty", 32'(m_valid), 0);

      // Stop coincident with a delayed capture strobe
      send(16'h0021, 1'b0);
      send(16'h0023, 1'b0);
      @(negedge clk);
      cic_data_clk = 1'b1;
      @(negedge clk);
      cic_data_clk = 1'b0;
      cic_data     = 16'h0022;
      stop         = 1'b1;
      m_ready      = 1'b1;
      @(posedge clk); #1;
      check("stop_cic_en", 32'(cic_en), 0);
      check("stop_busy", 32'(busy), 0);
      check("stop_ovf", 32'(overflow), 0);
      check("stop_head", 32'(m_data), 32'h23);
      @(negedge clk);
      stop = 1'b0;
      @(posedge clk); #1;
      check("stop_drained", 32'(m_valid), 0);
      send(16'h0099, 1'b1);
      check("idle_no_capture", 32'(m_valid), 0);

`ifdef CIC_SEQ_BURST_EN
      burst_len = 16'd3;
      for (int r = 0; r < 2; r++) begin
         do_start();
         settle(1'b1);
         for (int k = 0; k < 3; k++) begin
            send(16'h0030 + 16'(k), 1'b1);
            check("burst_data", 32'(m_data), 32'h30 + 32'(k));
            gap(2);
         end
         check("burst_busy", 32'(busy), 0);
         check("burst_cic_en", 32'(cic_en), 0);
         send(16'h003F, 1'b1);
         check("burst_extra", 32'(m_valid), 0);
      end
      burst_len = 16'd0;
`endif

      // Asynchronous reset in RUN with a non-empty FIFO
      do_start();
      settle(1'b0);
      send(16'h0041, 1'b0);
      send(16'h0042, 1'b0);
      check("prerst_busy", 32'(busy), 1);
      check("prerst_head", 32'(m_data), 32'h41);
      @(negedge clk);
      #2 arst_n = 1'b0;
      #1;
      check("arst_cic_en", 32'(cic_en), 0);
      check("arst_busy", 32'(busy), 0);
      check("arst_m_valid", 32'(m_valid), 0);
      check("arst_m_data", 32'(m_data), 0);
      check("arst_overflow", 32'(overflow), 0);
      @(negedge clk);
      arst_n = 1'b1;
      @(posedge clk); #1;
      check("post_rst_valid", 32'(m_valid), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/cic_seq.md
# cic_seq

Sequencer and output buffer for the CIC decimator. Gates the decimator's `en`, and discards the first outputs after every start while the comb pipeline flushes stale state. Captures each valid decimated sample into a small show-ahead FIFO and presents it to downstream logic on a valid/ready handshake. Runs in the CIC clock domain, between the CIC instance and the CSR/DMA sample path.

## Interface
- `DATA_WIDTH`, 16, width of CIC output sample and `m_data`
- `FIFO_DEPTH`, 4, output FIFO entries; power of two, >= 2
- `SETTLE_SAMPLES`, 5, decimated samples discarded after each start, 0..255
- `BURST_WIDTH`, 16, width of `burst_len`; used only with `CIC_SEQ_BURST_EN`

Ports:
- `clk`  in  1  system clock; the CIC and this block share it
- `arst_n`  in  1  asynchronous active-low reset
- `start`  in  1  one-cycle pulse: begin acquisition
- `stop`  in  1  one-cycle pulse: end acquisition
- `burst_len`  in  BURST_WIDTH  samples to deliver per start; 0 = unlimited (only with `CIC_SEQ_BURST_EN`)
- `cic_en`  out  1  drives CIC `en`
- `cic_data`  in  DATA_WIDTH  CIC `data_out`
- `cic_data_clk`  in  1  CIC `data_clk` strobe
- `m_data`  out  DATA_WIDTH  FIFO head sample
- `m_valid`  out  1  FIFO non-empty
- `m_ready`  in  1  downstream accepts head this cycle
- `busy`  out  1  state != IDLE
- `overflow`  out  1  sticky: a sample was dropped because the FIFO was full
- `overflow_clr`  in  1  clears `overflow`

## Operation
- States: IDLE, SETTLE, RUN.
- IDLE: `cic_en`=0. `start` goes to SETTLE, or to RUN if `SETTLE_SAMPLES`=0. Discard counter loads `SETTLE_SAMPLES`. Burst counter loads `burst_len`.
- SETTLE: `cic_en`=1. Each captured sample is discarded and decrements the counter. The discard that brings it to 0 moves to RUN.
- RUN: `cic_en`=1. Each captured sample is pushed to the FIFO.
- `stop` in SETTLE or RUN returns to IDLE. `cic_en` falls on the next edge. A capture in the same cycle as `stop`, or in any later cycle, is dropped and does not set `overflow`.
- `start` outside IDLE is ignored. `start` and `stop` together: `stop` wins.
- Capture timing: the CIC updates `data_out` on the edge that ends its `data_clk` cycle. The capture strobe is therefore `cic_data_clk` delayed by one register. `cic_data` is sampled in the cycle after `cic_data_clk`.
- FIFO: show-ahead. `m_data` is always the head entry; a pop occurs when `m_valid && m_ready`.
- `m_ready` with `m_valid`=0 has no effect.
- Push while full without a pop: the sample is dropped and `overflow` is set.
- Push and pop in the same cycle while full: both take effect and `overflow` is not set.
- Pointers wrap modulo `FIFO_DEPTH`. Occupancy is tracked with an extra pointer bit.
- `overflow_clr` and a new overflow in the same cycle: `overflow` stays 1.
- The FIFO keeps draining in IDLE. `start` does not flush it.
- Samples pass unchanged; no scaling or truncation in this block.

## Timing
- Reset values:
  - `cic_en`=0, `m_valid`=0, `m_data`=0, `busy`=0, `overflow`=0
  - state IDLE, FIFO empty, counters 0
- `start` at edge N: `busy` and `cic_en` are 1 after edge N.
- `cic_data_clk` high in cycle T: the sample is written at the end of cycle T+1. `m_valid` is 1 in cycle T+2 if the FIFO was empty.
- Pop at edge P: the next head appears on `m_data` in the cycle after P.
- Reset mid-operation: all state clears immediately, including FIFO contents and the delayed strobe.

## Configuration
- `CIC_SEQ_BURST_EN` defined:
  - the burst counter decrements on each push accepted in RUN
  - reaching 0 returns to IDLE with the same behaviour as `stop`
  - `burst_len`=0 means unlimited
  - dropped (overflow) samples do not count
- Not defined: `burst_len` is ignored; RUN continues until `stop`.

## Test plan
- Reset, `start`, CIC with decimation 8 and `SETTLE_SAMPLES`=5, `m_ready`=1 -> first 5 strobes discarded. The sixth strobe's `cic_data` appears on `m_data` with `m_valid` two cycles after that strobe.
- `m_ready`=0, 6 samples, `FIFO_DEPTH`=4 -> FIFO holds samples 1-4 in order and `overflow`=1. `overflow_clr` -> 0. Drain yields samples 1-4.
- FIFO full with `m_ready`=1 in the same cycle a sample is captured -> the sample is accepted and `overflow` stays 0.
- `stop` in the cycle of a delayed capture strobe -> sample dropped, `cic_en`=0 next cycle, FIFO keeps draining, `busy`=0.
- With `CIC_SEQ_BURST_EN` and `burst_len`=3 -> exactly 3 samples delivered, then `busy`=0 and `cic_en`=0. A repeat `start` delivers 3 more.
- `arst_n` asserted in RUN with a non-empty FIFO -> all outputs return to reset values within the same cycle.
